// File: rtl/rv_cache_assoc.sv
// Set-associative write-through cache (round-robin victim per set) with an uncached bypass window.
// Latency: read hit acks combinationally; miss refills the whole line, then hits. Writes and bypass finish on i_bus_ack.
// Backpressure: every bus transfer holds until i_bus_ack. RV_CACHE_STATS_EN adds the o_hit_count/o_miss_count outputs.
module rv_cache_assoc #(
  parameter int         WAYS_BIT      = 1,
  parameter int         LINE_SIZE_BIT = 2,
  parameter int         SET_COUNT_BIT = 3,
  parameter logic [3:0] ADDR_HI       = 4'h0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_addr,
  input  logic        i_read,
  input  logic        i_write,
  input  logic [3:0]  i_write_sel,
  input  logic [31:0] i_write_data,
  input  logic        i_flush,
  output logic [31:0] o_data,
  output logic        o_ack,
  output logic [31:0] o_bus_addr,
  output logic        o_bus_read,
  output logic        o_bus_write,
  output logic [3:0]  o_bus_sel,
  output logic [31:0] o_bus_data,
  input  logic [31:0] i_bus_data,
  input  logic        i_bus_ack
`ifdef RV_CACHE_STATS_EN
  ,
  output logic [31:0] o_hit_count,
  output logic [31:0] o_miss_count
`endif
);

  localparam int WAYS   = 1 << WAYS_BIT;
  localparam int WORDS  = 1 << LINE_SIZE_BIT;
  localparam int SETS   = 1 << SET_COUNT_BIT;
  localparam int SET_LO = 2 + LINE_SIZE_BIT;
  localparam int TAG_LO = SET_LO + SET_COUNT_BIT;
  localparam int TAG_W  = 28 - TAG_LO;
  localparam logic [LINE_SIZE_BIT-1:0] LAST_WORD = LINE_SIZE_BIT'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, BYPASS} state_t;
  state_t state_q, state_d;

  logic [WAYS-1:0]          valid_q  [SETS];
  logic [WAYS_BIT-1:0]      victim_q [SETS];
  logic [TAG_W-1:0]         tag_q    [SETS][WAYS];
  logic [31:0]              data_q   [SETS][WAYS][WORDS];

  logic [LINE_SIZE_BIT-1:0] refill_cnt_q;
  logic [WAYS_BIT-1:0]      refill_way_q;
  logic                     flush_pend_q;

  logic [LINE_SIZE_BIT-1:0] word_idx;
  logic [SET_COUNT_BIT-1:0] set_idx;
  logic [TAG_W-1:0]         addr_tag;
  logic                     cacheable;
  logic                     unused_addr;

  assign word_idx    = i_addr[SET_LO-1:2];
  assign set_idx     = i_addr[TAG_LO-1:SET_LO];
  assign addr_tag    = i_addr[27:TAG_LO];
  assign cacheable   = (i_addr[31:28] == ADDR_HI);
  assign unused_addr = ^i_addr[1:0];

  logic                hit;
  logic [WAYS_BIT-1:0] hit_way;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (cacheable && valid_q[set_idx][w] && (tag_q[set_idx][w] == addr_tag)) begin
        hit     = 1'b1;
        hit_way = WAYS_BIT'(w);
      end
    end
  end

  logic flush_now, start_refill, refill_done, fill_word, write_upd, rd_hit;

  always_comb begin
    state_d      = state_q;
    o_ack        = 1'b0;
    o_data       = '0;
    o_bus_addr   = '0;
    o_bus_read   = 1'b0;
    o_bus_write  = 1'b0;
    o_bus_sel    = '0;
    o_bus_data   = '0;
    flush_now    = 1'b0;
    start_refill = 1'b0;
    refill_done  = 1'b0;
    fill_word    = 1'b0;
    write_upd    = 1'b0;
    rd_hit       = 1'b0;
    case (state_q)
      IDLE: begin
        // A pending or fresh flush takes the whole cycle; the request is looked at afterwards.
        if (i_flush || flush_pend_q) begin
          flush_now = 1'b1;
        end else if (i_read || i_write) begin
          if (!cacheable) begin
            state_d = BYPASS;
          end else if (i_write) begin
            state_d = WRITE;
          end else if (hit) begin
            o_ack  = 1'b1;
            o_data = data_q[set_idx][hit_way][word_idx];
            rd_hit = 1'b1;
          end else begin
            state_d      = REFILL;
            start_refill = 1'b1;
          end
        end
      end
      REFILL: begin
        o_bus_read = 1'b1;
        o_bus_addr = {i_addr[31:SET_LO], refill_cnt_q, 2'b00};
        o_bus_sel  = 4'hF;
        fill_word  = i_bus_ack;
        if (i_bus_ack && (refill_cnt_q == LAST_WORD)) begin
          refill_done = 1'b1;
          state_d     = IDLE;
        end
      end
      WRITE: begin
        o_bus_write = 1'b1;
        o_bus_addr  = {i_addr[31:2], 2'b00};
        o_bus_sel   = i_write_sel;
        o_bus_data  = i_write_data;
        if (i_bus_ack) begin
          o_ack     = 1'b1;
          write_upd = hit;
          state_d   = IDLE;
        end
      end
      BYPASS: begin
        o_bus_addr = {i_addr[31:2], 2'b00};
        o_data     = i_bus_data;
        o_ack      = i_bus_ack;
        if (i_write) begin
          o_bus_write = 1'b1;
          o_bus_sel   = i_write_sel;
          o_bus_data  = i_write_data;
        end else begin
          o_bus_read = 1'b1;
          o_bus_sel  = 4'hF;
        end
        if (i_bus_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      refill_cnt_q <= '0;
      refill_way_q <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q != IDLE) && i_flush) flush_pend_q <= 1'b1;
      else if (flush_now)               flush_pend_q <= 1'b0;
      if (start_refill) begin
        refill_cnt_q <= '0;
        refill_way_q <= victim_q[set_idx];
      end else if (fill_word) begin
        refill_cnt_q <= refill_cnt_q + LINE_SIZE_BIT'(1);
      end
    end
  end

  // The victim is invalidated before refill so a half-overwritten line can never hit.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s]  <= '0;
        victim_q[s] <= '0;
      end
    end else if (flush_now) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s]  <= '0;
        victim_q[s] <= '0;
      end
    end else if (start_refill) begin
      valid_q[set_idx][victim_q[set_idx]] <= 1'b0;
    end else if (refill_done) begin
      valid_q[set_idx][refill_way_q] <= 1'b1;
      victim_q[set_idx]              <= victim_q[set_idx] + WAYS_BIT'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (refill_done) tag_q[set_idx][refill_way_q] <= addr_tag;
    if (fill_word)   data_q[set_idx][refill_way_q][refill_cnt_q] <= i_bus_data;
    if (write_upd) begin
      for (int b = 0; b < 4; b++) begin
        if (i_write_sel[b]) data_q[set_idx][hit_way][word_idx][8*b +: 8] <= i_write_data[8*b +: 8];
      end
    end
  end

`ifdef RV_CACHE_STATS_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_hit_count  <= '0;
      o_miss_count <= '0;
    end else begin
      if (rd_hit)       o_hit_count  <= o_hit_count + 32'd1;
      if (start_refill) o_miss_count <= o_miss_count + 32'd1;
    end
  end
`endif

endmodule
